rr_arbiter_8: RTL
=================

RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum cycles a grant may be held before forced release (legal 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  arbitration enable; low blocks new grants and revokes any active grant.
REQ-005 req  input  8  request vector, bit i = requester i.
REQ-006 done  input  1  release strobe from the granted requester, sampled only while a grant is active.
REQ-007 grant  output  8  registered one-hot grant, drives the downstream 8-to-3 encoder directly.
REQ-008 gnt_valid  output  1  registered, high while grant is non-zero.
REQ-009 gnt_idx  output  3  registered binary index of the granted bit; 3'b000 when gnt_valid is low.
REQ-010 timeout  output  1  registered one-cycle pulse, forced release caused by MAX_HOLD expiry.

Function
REQ-011 The block SHALL implement two states, IDLE and BUSY.
REQ-012 grant SHALL only ever be all-zero or exactly one-hot; gnt_valid SHALL equal |grant in every cycle.
REQ-013 In IDLE with en=1 and req!=0, the block SHALL select the first set req bit found scanning upward from ptr with wrap 7->0, and SHALL register it into grant, gnt_idx and gnt_valid=1 at the next edge, entering BUSY (1-cycle latency).
REQ-014 In IDLE with en=0 or req=0, the block SHALL stay in IDLE with grant=0.
REQ-015 ptr (3 bits) SHALL be loaded with gnt_idx+1 (mod 8) on every release of any kind, so the last winner becomes lowest priority.
REQ-016 In BUSY, grant SHALL be held unchanged while done=0, req[gnt_idx]=1, en=1 and the hold counter has not expired.
REQ-017 In BUSY, done=1 OR req[gnt_idx]=0 OR en=0 SHALL release: grant=0, gnt_valid=0, gnt_idx=0 at the next edge and return to IDLE.
REQ-018 The hold counter (8 bits) SHALL clear on grant issue and increment each BUSY cycle; when it equals MAX_HOLD-1 with no other release condition, the next edge SHALL release and assert timeout for exactly one cycle.
REQ-019 When a normal release condition and counter expiry coincide, the block SHALL release normally with timeout=0.
REQ-020 After any release, the block SHALL spend at least one cycle in IDLE with grant=0 before the next grant (no back-to-back grants).
REQ-021 Changes to req bits other than req[gnt_idx] during BUSY SHALL have no effect on the active grant.
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 Arbitration SHALL be starvation-free: any requester holding req high is granted within 8 grant cycles.

Reset
REQ-024 While rst_n=0, the block SHALL immediately (without a clock) force state=IDLE, grant=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0, hold counter=0.
REQ-025 Reset asserted mid-grant SHALL drop the grant asynchronously; the first arbitration after rst_n rises SHALL use ptr=0.
REQ-026 The first arbitration edge SHALL be the first rising clk edge after rst_n deasserts.

Verification
REQ-027 Reset, en=1, req=8'b00000101 -> next edge grant=8'b00000001, gnt_idx=0; done pulse -> grant=0 one cycle, then grant=8'b00000100, gnt_idx=2.
REQ-028 req=8'hFF held, done pulsed each BUSY cycle -> gnt_idx sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-029 MAX_HOLD=4, req=8'b10000000 held, done=0 -> grant=8'h80 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle, ptr=0, regrant to bit 7 after idle cycle.
REQ-030 Grant on bit 3, then req[3] dropped -> grant=0 next edge, ptr=4; done and expiry in same cycle -> timeout stays 0.
REQ-031 Grant active on bit 5, en driven low -> grant=0 next edge; rst_n pulsed low mid-grant -> grant=0 without clock edge, next grant with req=8'hFF is bit 0.
REQ-032 Random req/done/en for 10k cycles -> assert grant one-hot or zero, gnt_idx consistent with grant, no requester waits more than 8 grants.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time.
// A grant is issued from IDLE, held in BUSY until the owner signals done,
// drops its request, arbitration is disabled, or the hold counter expires.
// Every release rotates priority so the last winner becomes lowest priority.
// There is always at least one IDLE cycle between two grants.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Counter value in the last cycle a grant may be held.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;
  logic       rel_normal;
  logic       rel_expire;

  // Rotating priority search: first set request at or above ptr, wrapping 7->0.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 3'd0;
    cand       = 3'd0;
    // Scan from the farthest candidate down so the nearest one wins last.
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Release conditions while a grant is active.
  always_comb begin
    rel_normal = done | ~req[gnt_idx] | ~en;
    rel_expire = (hold_cnt == HOLD_LAST);
  end

  // Arbiter state, grant outputs, priority pointer and hold counter.
  // NOTE: the reset is asynchronous and active-low, so it appears in the
  // sensitivity list and clears all state without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= 8'd0;
      gnt_valid <= 1'b0;
      gnt_idx   <= 3'd0;
      timeout   <= 1'b0;
      ptr       <= 3'd0;
      hold_cnt  <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values and the block order does not matter.
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            state     <= BUSY;
            grant     <= 8'd1 << pick_idx;
            gnt_valid <= 1'b1;
            gnt_idx   <= pick_idx;
            hold_cnt  <= 8'd0;
          end
        end
        BUSY: begin
          if (rel_normal || rel_expire) begin
            state     <= IDLE;
            grant     <= 8'd0;
            gnt_valid <= 1'b0;
            gnt_idx   <= 3'd0;
            hold_cnt  <= 8'd0;
            ptr       <= gnt_idx + 3'd1;
            // A forced release only counts as a timeout when nothing else
            // would have released the grant in the same cycle.
            timeout   <= rel_expire & ~rel_normal;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          grant     <= 8'd0;
          gnt_valid <= 1'b0;
          gnt_idx   <= 3'd0;
          hold_cnt  <= 8'd0;
        end
      endcase
    end
  end

endmodule
